// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle ops and a shift-add multiplier behind a valid/ready handshake
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] DatA,
  input  logic [WIDTH-1:0] DatB,
  input  logic [3:0]       Alu_op,
  input  logic             CarryIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Rslt,
  output logic             Lt_flag,
  output logic             Overflow,
  output logic             Zero,
  output logic             Illegal
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2;
  logic [1:0]         state_q;
  logic [WIDTH-1:0]   a_q, r_d, mr;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0]     sum, acc;
  logic [CW-1:0]      cnt_q;
  logic               hi_q, lt_d, ov_d, z_d, ill_d, mov, is_mul;
  assign InReady  = state_q == IDLE;
  assign OutValid = state_q == DONE;
  assign is_mul   = Alu_op[3:1] == 3'b101;
  // single-cycle result computed straight from the inputs at the accept edge
  always_comb begin
    sum = {1'b0, DatA} + {1'b0, DatB} + {{WIDTH{1'b0}}, CarryIn};
    r_d = '0;
    lt_d = 1'b0;
    ov_d = 1'b0;
    ill_d = 1'b0;
    case (Alu_op)
      4'b0000: begin r_d = sum[WIDTH-1:0]; ov_d = sum[WIDTH]; end
      4'b0001: r_d = DatA & DatB;
      4'b0010: r_d = DatA ^ DatB;
      4'b0011: r_d = DatA << DatB;
      4'b0100: r_d = DatA >> DatB;
      4'b0101: begin
        r_d = sum[WIDTH-1:0];
        ov_d = (DatA[WIDTH-1] == DatB[WIDTH-1]) && (sum[WIDTH-1] != DatA[WIDTH-1]);
      end
      4'b0110: lt_d = DatA < DatB;
      4'b0111: r_d = DatB;
      4'b1000: r_d = $signed(DatA) >>> DatB;
      4'b1001: lt_d = $signed(DatA) < $signed(DatB);
      default: ill_d = Alu_op[3:2] == 2'b11;
    endcase
    z_d = (r_d == '0) && !ill_d;
  end
  // one shift-add step: add multiplicand into the upper half when the current multiplier bit is set, then shift right
  always_comb begin
    acc = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_d = {acc, p_q[WIDTH-1:1]};
    mr  = hi_q ? p_d[2*WIDTH-1:WIDTH] : p_d[WIDTH-1:0];
    mov = !hi_q && (p_d[2*WIDTH-1:WIDTH] != '0);
  end
  // control FSM and registered result/flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      Rslt     <= '0;
      Lt_flag  <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (InValid) begin
          if (is_mul) begin
            state_q <= MUL;
            a_q     <= DatA;
            p_q     <= {{WIDTH{1'b0}}, DatB};
            hi_q    <= Alu_op[0];
            cnt_q   <= '0;
          end else begin
            state_q  <= DONE;
            Rslt     <= r_d;
            Lt_flag  <= lt_d;
            Overflow <= ov_d;
            Zero     <= z_d;
            Illegal  <= ill_d;
          end
        end
        MUL: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            Rslt     <= mr;
            Lt_flag  <= 1'b0;
            Overflow <= mov;
            Zero     <= mr == '0;
            Illegal  <= 1'b0;
          end
        end
        DONE: if (OutReady) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc against an integer reference model
module tb_alu_mc;
  typedef struct packed {
    logic [7:0] r;
    logic       lt, ov, z, ill;
  } exp_t;
  logic       Clk = 1'b0, Reset = 1'b1, InValid = 1'b0, OutReady = 1'b0, CarryIn = 1'b0;
  logic       InReady, OutValid, Lt_flag, Overflow, Zero, Illegal;
  logic [7:0] DatA = '0, DatB = '0, Rslt;
  logic [3:0] Alu_op = '0;
  int total = 0, bad = 0;
  alu_mc #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .DatA(DatA), .DatB(DatB), .Alu_op(Alu_op), .CarryIn(CarryIn),
    .OutValid(OutValid), .OutReady(OutReady), .Rslt(Rslt),
    .Lt_flag(Lt_flag), .Overflow(Overflow), .Zero(Zero), .Illegal(Illegal)
  );
  always #5 Clk = ~Clk;
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int ua, ub, sa, sb, c, s;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    c  = int'(cin);
    sa = ua > 127 ? ua - 256 : ua;
    sb = ub > 127 ? ub - 256 : ub;
    e = '0;
    case (op)
      4'd0: begin s = ua + ub + c; e.r = 8'(s); e.ov = s > 255; end
      4'd1: e.r = a & b;
      4'd2: e.r = a ^ b;
      4'd3: e.r = ub >= 8 ? 8'h00 : 8'(ua * (2 ** ub));
      4'd4: e.r = ub >= 8 ? 8'h00 : 8'(ua / (2 ** ub));
      4'd5: begin s = sa + sb + c; e.r = 8'(s); e.ov = s > 127 || s < -128; end
      4'd6: e.lt = ua < ub;
      4'd7: e.r = b;
      4'd8: e.r = ub >= 8 ? (sa < 0 ? 8'hFF : 8'h00) : 8'(sa >>> ub);
      4'd9: e.lt = sa < sb;
      4'd10: begin s = ua * ub; e.r = 8'(s); e.ov = s > 255; end
      4'd11: e.r = 8'(ua * ub / 256);
      default: e.ill = 1'b1;
    endcase
    e.z = e.r == 8'h00 && !e.ill;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic scramble();
    DatA = 8'($urandom);
    DatB = 8'($urandom);
    Alu_op = 4'($urandom);
    CarryIn = 1'($urandom);
    InValid = 1'($urandom);
  endtask
  task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin, input int hold, input string tag);
    exp_t e;
    int lat;
    e = model(op, a, b, cin);
    @(negedge Clk);
    chk({tag, "_ready"}, {30'd0, InReady, OutValid}, 32'b10);
    Alu_op = op;
    DatA = a;
    DatB = b;
    CarryIn = cin;
    InValid = 1'b1;
    OutReady = 1'($urandom);
    @(posedge Clk);
    #1;
    scramble();
    OutReady = 1'($urandom);
    lat = 1;
    @(negedge Clk);
    while (OutValid !== 1'b1 && lat < 40) begin
      scramble();
      OutReady = 1'($urandom);
      @(negedge Clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (op == 4'd10 || op == 4'd11) ? 32'd9 : 32'd1);
    chk({tag, "_out"}, {20'd0, Rslt, Lt_flag, Overflow, Zero, Illegal}, {20'd0, e});
    OutReady = 1'b0;
    InValid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      scramble();
      InValid = 1'b1;
      chk({tag, "_hold"}, {18'd0, OutValid, InReady, Rslt, Lt_flag, Overflow, Zero, Illegal}, {18'd0, 1'b1, 1'b0, e});
    end
    OutReady = 1'b1;
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
  endtask
  initial begin
    logic seen;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset", {18'd0, InReady, OutValid, Rslt, Lt_flag, Overflow, Zero, Illegal}, {18'd0, 2'b10, 12'd0});
    Reset = 1'b0;
    run(4'b0000, 8'hF0, 8'h20, 1'b1, 0, "add_u");
    run(4'b0101, 8'h7F, 8'h01, 1'b0, 0, "add_s");
    run(4'b1000, 8'h90, 8'h02, 1'b0, 0, "sra");
    run(4'b0011, 8'hFF, 8'h09, 1'b0, 0, "sll_big");
    run(4'b1010, 8'h10, 8'h20, 1'b0, 0, "mullo");
    run(4'b1011, 8'h10, 8'h20, 1'b0, 0, "mulhi");
    run(4'b1001, 8'hFF, 8'h01, 1'b0, 0, "slt");
    run(4'b0110, 8'hFF, 8'h01, 1'b0, 0, "sltu");
    run(4'b1101, 8'h12, 8'h34, 1'b1, 0, "illegal");
    run(4'b1000, 8'h81, 8'h0C, 1'b0, 0, "sra_big");
    run(4'b0100, 8'hFF, 8'h08, 1'b0, 0, "srl_big");
    run(4'b0010, 8'h5A, 8'hA5, 1'b0, 5, "xor_hold");
    run(4'b1010, 8'hFF, 8'hFF, 1'b0, 5, "mullo_hold");
    @(negedge Clk);
    Alu_op = 4'b1010;
    DatA = 8'h33;
    DatB = 8'h44;
    InValid = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mul", {18'd0, InReady, OutValid, Rslt, Lt_flag, Overflow, Zero, Illegal}, {18'd0, 2'b10, 12'd0});
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      seen = seen | OutValid;
    end
    chk("rst_mul_nopulse", {31'd0, seen}, 32'd0);
    @(negedge Clk);
    Alu_op = 4'b0111;
    DatB = 8'h5C;
    InValid = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(negedge Clk);
    chk("mov_pre_rst", {23'd0, OutValid, Rslt}, {23'd0, 1'b1, 8'h5C});
    Reset = 1'b1;
    InValid = 1'b1;
    OutReady = 1'b1;
    Alu_op = 4'b0000;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b0;
    @(negedge Clk);
    chk("rst_prio", {18'd0, InReady, OutValid, Rslt, Lt_flag, Overflow, Zero, Illegal}, {18'd0, 2'b10, 12'd0});
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run(4'($urandom), 8'($urandom), b, 1'($urandom), $urandom_range(0, 2), "rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
